intt16_stream: RTL and testbench

Streaming 16-point inverse NTT over Z_7681. It is the receive-side counterpart of the 16x16 forward-NTT systolic array, which uses ω=7098, a 16th root of unity.
- Accepts 16 frequency-domain coefficients X[0..15] serially on a valid/ready input.
- Computes x[j] = 16^-1 · Σ_k X[k]·ω^(-jk) mod 7681 with a single sequential MAC.
- Emits x[0..15] serially on a valid/ready output.
- Used to check round-trip NTT→INTT and as the back end of polynomial-multiply datapaths.

---
 rtl/ntt_pkg.sv | 16 +
 rtl/mod_mul_q.sv | 13 +
 rtl/intt16_stream.sv | 84 ++++++++
 tb/tb_intt16_stream.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg: shared Z_7681 constants, twiddle ROMs and stream state enum
package ntt_pkg;
  localparam int Q = 7681;
  localparam int N = 16;
  localparam int LOGN = 4;
  localparam int DW = 13;
  localparam logic [DW-1:0] Q_D = DW'(Q);
  localparam logic [DW-1:0] N_INV = 13'd7201;
  localparam logic [DW-1:0] TW_FWD [N] = '{
    13'd1, 13'd7098, 13'd1925, 13'd6832, 13'd3383, 13'd1728, 13'd6468, 13'd527,
    13'd7680, 13'd583, 13'd5756, 13'd849, 13'd4298, 13'd5953, 13'd1213, 13'd7154};
  localparam logic [DW-1:0] TW_INV [N] = '{
    13'd1, 13'd7154, 13'd1213, 13'd5953, 13'd4298, 13'd849, 13'd5756, 13'd583,
    13'd7680, 13'd527, 13'd6468, 13'd1728, 13'd3383, 13'd6832, 13'd1925, 13'd7098};
  typedef enum logic [1:0] {LOAD, COMPUTE, SCALE, OUTPUT} state_t;
endpackage

// File: rtl/mod_mul_q.sv
// mod_mul_q: combinational y = (a*b) mod Q for a, b < Q
module mod_mul_q
  import ntt_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);
  logic [2*DW-1:0] p, r;
  assign p = a * b;
  assign r = p % (2*DW)'(Q);
  assign y = r[DW-1:0];
endmodule

// File: rtl/intt16_stream.sv
// intt16_stream: streaming 16-point inverse NTT over Z_7681 (serial in, one MAC, serial out)
module intt16_stream
  import ntt_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic [LOGN-1:0] out_index,
  output logic            out_last,
  output logic            busy
);
  state_t state, state_n;
  logic [LOGN-1:0] cnt, j, k, tw_idx;
  logic [DW-1:0] coef [N];
  logic [DW-1:0] acc, mul_a, mul_b, prod, din_mod, acc_sum;
  logic [DW:0] sum_raw;
  assign in_ready = state == LOAD;
  assign out_valid = state == OUTPUT;
  assign busy = state != LOAD;
  assign din_mod = in_data >= Q_D ? in_data - Q_D : in_data;
  assign tw_idx = LOGN'(j * k);
  // one multiplier serves both the MAC product and the final 1/N scaling
  assign mul_a = state == SCALE ? acc : coef[k];
  assign mul_b = state == SCALE ? N_INV : TW_INV[tw_idx];
  assign sum_raw = {1'b0, acc} + {1'b0, prod};
  assign acc_sum = sum_raw >= {1'b0, Q_D} ? DW'(sum_raw - {1'b0, Q_D}) : sum_raw[DW-1:0];
  mod_mul_q u_mul (.a(mul_a), .b(mul_b), .y(prod));
  always_ff @(posedge clk)
    if (rst) state <= LOAD;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      LOAD:    state_n = in_valid && cnt == LOGN'(N - 1) ? COMPUTE : LOAD;
      COMPUTE: state_n = k == LOGN'(N - 1) ? SCALE : COMPUTE;
      SCALE:   state_n = OUTPUT;
      OUTPUT:  state_n = !out_ready ? OUTPUT : j == LOGN'(N - 1) ? LOAD : COMPUTE;
      default: state_n = LOAD;
    endcase
  end
  always_ff @(posedge clk)
    if (state == LOAD && in_valid) coef[cnt] <= din_mod;
  // counters wrap naturally at 16, so cnt/k/j return to 0 without explicit clears
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      j <= '0;
      k <= '0;
      acc <= '0;
      out_data <= '0;
      out_index <= '0;
      out_last <= 1'b0;
    end else
      case (state)
        LOAD:
          if (in_valid) begin
            cnt <= cnt + 1'b1;
            j <= '0;
            k <= '0;
            acc <= '0;
          end
        COMPUTE: begin
          acc <= acc_sum;
          k <= k + 1'b1;
        end
        SCALE: begin
          out_data <= prod;
          out_index <= j;
          out_last <= j == LOGN'(N - 1);
        end
        OUTPUT:
          if (out_ready) begin
            j <= j + 1'b1;
            k <= '0;
            acc <= '0;
          end
        default: ;
      endcase
endmodule

// File: tb/tb_intt16_stream.sv
// tb_intt16_stream: directed + random checks of intt16_stream against an arithmetic INTT model
module tb_intt16_stream;
  localparam longint QM = 7681;
  localparam longint OMEGA = 7098;
  typedef int blk_t [16];
  int cmp = 0;
  int fails = 0;
  logic clk = 0;
  logic rst = 1;
  logic in_valid = 0;
  logic out_ready = 0;
  logic [12:0] in_data = '0;
  logic in_ready, out_valid, out_last, busy;
  logic [12:0] out_data;
  logic [3:0] out_index;
  intt16_stream dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    cmp++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic longint powm(longint b, longint e);
    longint r = 1;
    for (longint i = 0; i < e; i++) r = r * b % QM;
    return r;
  endfunction
  task automatic model_intt(input blk_t xf, output blk_t xt);
    longint winv = powm(OMEGA, 15);
    longint ninv = powm(16, QM - 2);
    for (int jj = 0; jj < 16; jj++) begin
      longint s = 0;
      for (int kk = 0; kk < 16; kk++)
        s = (s + (longint'(xf[kk]) % QM) * powm(winv, longint'((jj * kk) % 16))) % QM;
      xt[jj] = int'(s * ninv % QM);
    end
  endtask
  task automatic model_ntt(input blk_t xt, output blk_t xf);
    for (int kk = 0; kk < 16; kk++) begin
      longint s = 0;
      for (int jj = 0; jj < 16; jj++)
        s = (s + longint'(xt[jj]) * powm(OMEGA, longint'((jj * kk) % 16))) % QM;
      xf[kk] = int'(s);
    end
  endtask
  task automatic send(input blk_t xf);
    for (int kk = 0; kk < 16; kk++) begin
      in_valid = 1;
      in_data = 13'(xf[kk]);
      step();
    end
    in_valid = 0;
  endtask
  // mode 0: out_ready held high, checks spacing; mode 1: random backpressure, checks stability
  task automatic recv(input blk_t exp, input int mode);
    int waitc;
    int d0, i0;
    out_ready = mode == 0;
    for (int jj = 0; jj < 16; jj++) begin
      waitc = 0;
      while (!out_valid && waitc < 400) begin
        step();
        waitc++;
      end
      chk("valid_timeout", int'(out_valid), 1);
      if (jj == 0) chk("latency", waitc, 17);
      else if (mode == 0) chk("gap", waitc + 1, 18);
      chk("data", int'(out_data), exp[jj]);
      chk("index", int'(out_index), jj);
      chk("last", int'(out_last), int'(jj == 15));
      if (mode == 1) begin
        d0 = int'(out_data);
        i0 = int'(out_index);
        repeat ($urandom_range(0, 4)) begin
          step();
          chk("stall_valid", int'(out_valid), 1);
          chk("stall_data", int'(out_data), d0);
          chk("stall_index", int'(out_index), i0);
        end
        out_ready = 1;
      end
      step();
      if (mode == 1) out_ready = 0;
    end
    out_ready = 0;
    chk("in_ready_after", int'(in_ready), 1);
    chk("valid_after", int'(out_valid), 0);
  endtask
  initial begin
    blk_t xf, xt, rt;
    step();
    step();
    rst = 0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_index", int'(out_index), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_busy", int'(busy), 0);
    xf = '{default: 0}; xf[0] = 16;
    model_intt(xf, xt); send(xf); recv(xt, 0);
    xf = '{default: 0}; xf[0] = 1;
    model_intt(xf, xt); send(xf); recv(xt, 0);
    xf = '{default: 0}; xf[1] = 16;
    model_intt(xf, xt); send(xf); recv(xt, 1);
    xf = '{default: 16};
    model_intt(xf, xt); send(xf); recv(xt, 0);
    for (int i = 0; i < 16; i++) rt[i] = i + 1;
    model_ntt(rt, xf); send(xf); recv(rt, 1);
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) xf[i] = int'($urandom_range(0, 8191));
      model_intt(xf, xt); send(xf); recv(xt, b % 2);
    end
    for (int i = 0; i < 16; i++) xf[i] = int'($urandom_range(0, 7680));
    send(xf);
    out_ready = 1;
    repeat (95) step();
    chk("busy_mid", int'(busy), 1);
    chk("in_ready_mid", int'(in_ready), 0);
    rst = 1;
    step();
    rst = 0;
    out_ready = 0;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_busy", int'(busy), 0);
    xf = '{default: 0}; xf[0] = 16;
    model_intt(xf, xt); send(xf); recv(xt, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end
endmodule
